// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional macro: FETCH_PERF_CNT_EN (see fetch_stage.sv).
package fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  // Queue entry for the default 32-bit address width; the top builds the
  // same layout at its own ADDR_W.
  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch queue: DEPTH entries (power of two), synchronous flush that
// overrides push/pop, head entry presented combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  entry_t                     i_din,
  output entry_t                     o_dout,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, internal byte memory (big-endian words),
// fetch queue, redirect/flush handling and sticky misaligned-target fault.
// Optional macro: FETCH_PERF_CNT_EN enables the fetch/flush counters;
// without it both counters are tied to zero.
//
// state | meaning
// RUN   | fetching sequentially, redirects accepted
// FAULT | misaligned redirect seen; no fetches, redirects ignored until reset
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                MEM_BYTES = 256,
  parameter int                DEPTH     = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_waddr,
  input  logic [7:0]         mem_wdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               fault,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        flush_cnt
);

  localparam int MA_W  = $clog2(MEM_BYTES);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [7:0]        r_mem [MEM_BYTES];
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_empty;
  logic              w_full;
  logic [CNT_W-1:0]  w_count;
  logic [MA_W-1:0]   w_idx0, w_idx1, w_idx2, w_idx3;
  entry_t            w_din;
  entry_t            w_head;
  logic              w_unused_waddr;

  // Byte memory is not reset; reads below see the pre-write contents.
  always_ff @(posedge clk) begin
    if (mem_we) r_mem[mem_waddr[MA_W-1:0]] <= mem_wdata;
  end

  assign w_unused_waddr = ^mem_waddr[ADDR_W-1:MA_W];

  assign w_idx0 = r_pc[MA_W-1:0];
  assign w_idx1 = w_idx0 + MA_W'(1);
  assign w_idx2 = w_idx0 + MA_W'(2);
  assign w_idx3 = w_idx0 + MA_W'(3);

  assign w_din.instr = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};
  assign w_din.pc    = r_pc;

  assign w_pop = instr_valid & instr_ready;

  // Next-state, PC update and queue control; redirect outranks fetching.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      RUN: begin
        if (redirect) begin
          w_flush = 1'b1;
          if (redirect_pc[1:0] != 2'b00) w_state_nxt = FAULT;
          else                           w_pc_nxt    = redirect_pc;
        end else if (!w_full || w_pop) begin
          w_push   = 1'b1;
          w_pc_nxt = r_pc + ADDR_W'(4);
        end
      end
      FAULT: ;
      default: w_state_nxt = RUN;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign instr_valid = !w_empty;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign pc_plus4    = w_head.pc + ADDR_W'(4);
  assign fault       = (r_state == FAULT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_discard;

  // A word popped in the same cycle as the flush was consumed, not discarded.
  assign w_discard = w_flush && (w_count > CNT_W'(w_pop));

  // Performance counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_push)    r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_discard) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^w_count;
  assign fetch_cnt    = '0;
  assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with default parameters.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_plus4    (pc_plus4),
    .fault       (fault),
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_fault;
    int          e_fetch;
    int          e_flush;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(logic redir, logic [31:0] rpc, logic rdy,
                              logic ev, logic [31:0] ei, logic [31:0] ep,
                              logic ef, int efe, int efl);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_fault = ef;
    v.e_fetch = efe; v.e_flush = efl;
    return v;
  endfunction

  function automatic logic [7:0] byte_at(int i);
    case (i)
      0: return 8'h11;
      1: return 8'h22;
      2: return 8'h33;
      3: return 8'h44;
      4: return 8'h55;
      5: return 8'h66;
      6: return 8'h77;
      7: return 8'h88;
      default: return i[7:0];
    endcase
  endfunction

  function automatic logic [31:0] exp_cnt(int v);
`ifdef FETCH_PERF_CNT_EN
    return v[31:0];
`else
    return 32'd0 & v[31:0];
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " valid"},    {31'd0, instr_valid}, 32'd0);
    chk({tag, " instr"},    instr,    32'd0);
    chk({tag, " instr_pc"}, instr_pc, 32'd0);
    chk({tag, " pc_plus4"}, pc_plus4, 32'd4);
    chk({tag, " fault"},    {31'd0, fault}, 32'd0);
    chk({tag, " fetch_cnt"}, fetch_cnt, 32'd0);
    chk({tag, " flush_cnt"}, flush_cnt, 32'd0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ei, input logic [31:0] ep);
    chk({tag, " valid"},    {31'd0, instr_valid}, 32'd1);
    chk({tag, " instr"},    instr,    ei);
    chk({tag, " instr_pc"}, instr_pc, ep);
    chk({tag, " pc_plus4"}, pc_plus4, ep + 32'd4);
  endtask

  initial begin
    // drive: redir, rpc, rdy | expect: valid, instr, pc, fault, fetch, flush
    vt[0]  = mk(0, 32'h0,  0, 1, 32'h11223344, 32'h0,   0, 1, 0);
    vt[1]  = mk(0, 32'h0,  0, 1, 32'h11223344, 32'h0,   0, 2, 0);
    vt[2]  = mk(0, 32'h0,  0, 1, 32'h11223344, 32'h0,   0, 2, 0);
    vt[3]  = mk(0, 32'h0,  0, 1, 32'h11223344, 32'h0,   0, 2, 0);
    vt[4]  = mk(0, 32'h0,  0, 1, 32'h11223344, 32'h0,   0, 2, 0);
    vt[5]  = mk(0, 32'h0,  1, 1, 32'h11223344, 32'h0,   0, 2, 0);
    vt[6]  = mk(0, 32'h0,  0, 1, 32'h55667788, 32'h4,   0, 3, 0);
    vt[7]  = mk(1, 32'h40, 0, 1, 32'h55667788, 32'h4,   0, 3, 0);
    vt[8]  = mk(0, 32'h0,  0, 0, 32'h0,        32'h0,   0, 3, 1);
    vt[9]  = mk(1, 32'hFC, 1, 1, 32'h40414243, 32'h40,  0, 4, 1);
    vt[10] = mk(0, 32'h0,  1, 0, 32'h0,        32'h0,   0, 4, 1);
    vt[11] = mk(0, 32'h0,  1, 1, 32'hFCFDFEFF, 32'hFC,  0, 5, 1);
    vt[12] = mk(1, 32'h42, 0, 1, 32'h11223344, 32'h100, 0, 6, 1);
    vt[13] = mk(1, 32'h80, 1, 0, 32'h0,        32'h0,   1, 6, 2);
    vt[14] = mk(0, 32'h0,  1, 0, 32'h0,        32'h0,   1, 6, 2);
    vt[15] = mk(0, 32'h0,  0, 0, 32'h0,        32'h0,   1, 6, 2);

    rst_n = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    // Load memory while held in reset.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      mem_we = 1'b1; mem_waddr = i; mem_wdata = byte_at(i);
    end
    @(negedge clk);
    mem_we = 1'b0;
    chk_reset_outputs("initial_reset");
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d valid", k), {31'd0, instr_valid}, {31'd0, vt[k].e_valid});
      chk($sformatf("v%0d fault", k), {31'd0, fault}, {31'd0, vt[k].e_fault});
      chk($sformatf("v%0d fetch_cnt", k), fetch_cnt, exp_cnt(vt[k].e_fetch));
      chk($sformatf("v%0d flush_cnt", k), flush_cnt, exp_cnt(vt[k].e_flush));
      if (vt[k].e_valid) chk_head($sformatf("v%0d", k), vt[k].e_instr, vt[k].e_pc);
      redirect    = vt[k].redir;
      redirect_pc = vt[k].rpc;
      instr_ready = vt[k].rdy;
    end

    // Reset pulse clears the fault; a write coinciding with the first fetch
    // of byte 0 must not be seen by that fetch.
    @(negedge clk);
    redirect = 1'b0; instr_ready = 1'b1; rst_n = 1'b0;
    #1 chk_reset_outputs("fault_exit_reset");
    @(negedge clk);
    rst_n = 1'b1; mem_we = 1'b1; mem_waddr = 32'h0; mem_wdata = 8'h99;
    @(negedge clk);
    mem_we = 1'b0;
    chk_head("post_reset_w0", 32'h11223344, 32'h0);
    @(negedge clk);
    chk_head("post_reset_w1", 32'h55667788, 32'h4);
    chk("post_reset fetch_cnt", fetch_cnt, exp_cnt(2));

    // One-cycle reset mid-stream, then restart from address 0.
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midstream_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_head("restart_w0", 32'h99223344, 32'h0);
    chk("restart fault", {31'd0, fault}, 32'd0);
    chk("restart fetch_cnt", fetch_cnt, exp_cnt(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
